// File: rtl/mux_select_arbiter_8_pkg.sv
// Shared definitions for the round-robin mux select arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux_select_arbiter_8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface mux_select_arbiter_8_if;
  import mux_arb_pkg::*;

  logic             arb_enable;
  logic [N_REQ-1:0] request_lines;
  logic [N_REQ-1:0] grant_lines;
  logic [SEL_W-1:0] select_lines;
  logic             grant_valid;
  logic             timeout_pulse;

  modport master (output arb_enable, request_lines,
                  input  grant_lines, select_lines, grant_valid, timeout_pulse);
  modport slave  (input  arb_enable, request_lines,
                  output grant_lines, select_lines, grant_valid, timeout_pulse);
endinterface

// File: rtl/mux_select_arbiter_8_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from the top index back to 0.
module rr_priority_picker
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] request_lines_i,
  input  logic [SEL_W-1:0] pointer_i,
  output logic             any_req_o,
  output logic [SEL_W-1:0] winner_o
);

  logic [SEL_W-1:0] idx;

  // Scan offsets from far to near so the nearest set request wins last.
  always_comb begin
    any_req_o = |request_lines_i;
    winner_o  = '0;
    idx       = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = pointer_i + SEL_W'(k);
      if (request_lines_i[idx]) winner_o = idx;
    end
  end

endmodule

// File: rtl/mux_select_arbiter_8.sv
// Round-robin arbiter driving the select input of a shared 8:1 mux.
// Optional feature: define ARB_TIMEOUT_EN to force release after MAX_HOLD
// grant cycles and flag it on timeout_pulse.
module mux_select_arbiter_8
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  mux_select_arbiter_8_if.slave  bus
);

  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow to count MAX_HOLD cycles");
  end

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             gv_q,    gv_d;
  logic             any_req;
  logic [SEL_W-1:0] winner;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             to_q,    to_d;
`endif

  rr_priority_picker u_pick (
    .request_lines_i (bus.request_lines),
    .pointer_i       (ptr_q),
    .any_req_o       (any_req),
    .winner_o        (winner)
  );

  // Next-state: grant in IDLE when enabled, release in GRANT on drop/timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    gv_d    = gv_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.arb_enable && any_req) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << winner;
          sel_d   = winner;
          gv_d    = 1'b1;
          ptr_d   = winner + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        // select_lines is left holding the last index on release.
        if (!bus.request_lines[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD-1)) begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      gv_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      gv_q    <= gv_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.grant_lines  = grant_q;
  assign bus.select_lines = sel_q;
  assign bus.grant_valid  = gv_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_pulse = to_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_mux_select_arbiter_8.sv
// Self-checking bench for mux_select_arbiter_8 (also covers ARB_TIMEOUT_EN builds).
module tb_mux_select_arbiter_8;

`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux_select_arbiter_8_if bus();

  mux_select_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the mux (-1 = nobody), where the next search starts,
  // how many cycles the current grant has been visible, last index shown.
  int m_g = -1, m_ptr = 0, m_sel = 0, m_held = 0;
  bit m_to = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_g = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_g < 0) begin
        if (bus.arb_enable && bus.request_lines != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (m_g < 0 && bus.request_lines[(m_ptr + k) % 8]) m_g = (m_ptr + k) % 8;
          end
          m_sel = m_g; m_ptr = (m_g + 1) % 8; m_held = 1;
        end
      end else if (!bus.request_lines[m_g]) begin
        m_g = -1;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_held == MH) begin m_g = -1; m_to = 1'b1; end
        else m_held++;
`endif
      end
    end
  end

  // Every cycle, compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    chk("m_grant", bus.grant_lines, (m_g < 0) ? 32'h0 : (32'h1 << m_g));
    chk("m_sel",   bus.select_lines, m_sel);
    chk("m_valid", bus.grant_valid, (m_g >= 0));
    chk("m_tout",  bus.timeout_pulse, m_to);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 reset = 1'b1;
    #4 reset = 1'b0;
  endtask

  int order[$];
  int drop_at[8];
  int raise_at[8];
  int exp_order[5] = '{0, 3, 7, 0, 3};
  bit prev_gv;

  initial begin
    bus.arb_enable = 1'b1;
    bus.request_lines = 8'h00;
    #1 reset = 1'b1;
    #10 reset = 1'b0;
    step();
    chk("rst_grant", bus.grant_lines, 8'h00);
    chk("rst_valid", bus.grant_valid, 1'b0);
    chk("rst_sel",   bus.select_lines, 3'd0);

    // Single requester.
    bus.request_lines = 8'h04; step();
    chk("t1_grant", bus.grant_lines, 8'h04);
    chk("t1_sel",   bus.select_lines, 3'b010);
    chk("t1_valid", bus.grant_valid, 1'b1);
    bus.request_lines = 8'h00; step();
    chk("t1_drop", bus.grant_lines, 8'h00);
    chk("t1_selkeep", bus.select_lines, 3'b010);

    // Round-robin over 0,3,7 with drop/re-raise.
    do_reset();
    for (int j = 0; j < 8; j++) begin drop_at[j] = -1; raise_at[j] = -1; end
    bus.request_lines = 8'h89; prev_gv = 1'b0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      step();
      for (int j = 0; j < 8; j++) begin
        if (drop_at[j] == c)  bus.request_lines[j] = 1'b0;
        if (raise_at[j] == c) bus.request_lines[j] = 1'b1;
      end
      if (bus.grant_valid && !prev_gv) begin
        order.push_back(int'(bus.select_lines));
        drop_at[bus.select_lines]  = c + 1;
        raise_at[bus.select_lines] = c + 2;
      end
      prev_gv = bus.grant_valid;
    end
    chk("t2_count", order.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    bus.request_lines = 8'h00; step(); step();

    // Wrap: grant 7, then 0 wins over 7.
    do_reset();
    bus.request_lines = 8'h80; step();
    chk("t3_g7", bus.grant_lines, 8'h80);
    bus.request_lines = 8'h00; step();
    bus.request_lines = 8'h81; step();
    chk("t3_wrap", bus.grant_lines, 8'h01);
    chk("t3_sel",  bus.select_lines, 3'd0);
    bus.request_lines = 8'h00; step(); step();

`ifdef ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles, then alternation.
    do_reset();
    bus.request_lines = 8'h03; step();
    chk("t4_g0", bus.grant_lines, 8'h01);
    for (int i = 0; i < 3; i++) begin step(); chk("t4_hold", bus.grant_lines, 8'h01); end
    step();
    chk("t4_rel",   bus.grant_lines, 8'h00);
    chk("t4_pulse", bus.timeout_pulse, 1'b1);
    step();
    chk("t4_g1",    bus.grant_lines, 8'h02);
    chk("t4_pdone", bus.timeout_pulse, 1'b0);
    for (int i = 0; i < 10; i++) step();
    bus.request_lines = 8'h00; step(); step();
`endif

    // Async reset mid-grant.
    do_reset();
    bus.request_lines = 8'h20; step();
    chk("t5_g5", bus.grant_lines, 8'h20);
    #2 reset = 1'b1;
    #1;
    chk("t5_rgrant", bus.grant_lines, 8'h00);
    chk("t5_rvalid", bus.grant_valid, 1'b0);
    chk("t5_rsel",   bus.select_lines, 3'd0);
    #1 reset = 1'b0;
    bus.request_lines = 8'hFF; step();
    chk("t5_g0",  bus.grant_lines, 8'h01);
    chk("t5_sel", bus.select_lines, 3'd0);
    bus.request_lines = 8'h00; step(); step();

    // Enable gating.
    do_reset();
    bus.arb_enable = 1'b0; bus.request_lines = 8'h10;
    for (int i = 0; i < 5; i++) begin step(); chk("t6_nogrant", bus.grant_valid, 1'b0); end
    bus.arb_enable = 1'b1; step();
    chk("t6_grant", bus.grant_lines, 8'h10);
    chk("t6_sel",   bus.select_lines, 3'b100);
    bus.request_lines = 8'h00; step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
